dmem_ctrl: RTL



---
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Memory-stage <-> data-memory controller bus: request fields in, load result,
// stall and LED/misalign status out.
interface dmem_if #(
    parameter int LED_WIDTH = 8
);
    logic [31:0]          addr;
    logic [31:0]          write_data;
    logic                 memwrite;
    logic                 memread;
    logic [3:0]           sign_mask;
    logic [31:0]          read_data;
    logic                 clk_stall;
    logic [LED_WIDTH-1:0] led;
    logic                 misalign;

    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, clk_stall, led, misalign
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, clk_stall, led, misalign
    );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: 3-cycle byte/half/word access to a word RAM plus an MMIO LED register.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word accesses are suppressed and flagged).
module dmem_ctrl #(
    parameter int          ADDR_WIDTH    = 10,
    parameter logic [31:0] MMIO_LED_ADDR = 32'h2000,
    parameter int          LED_WIDTH     = 8
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, READ, WRITE} state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           smask_q, smask_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 stall_q, stall_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 mis_q, mis_d;

    logic [31:0]           ram_q [2**ADDR_WIDTH];
    logic [31:0]           word_q;
    logic [ADDR_WIDTH-1:0] widx;

    logic        is_word, is_half, is_mmio, is_oob, misal, ram_we;
    logic [31:0] led_ext, src, ld_val, st_val, st_rep;
    logic [3:0]  be;
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    assign widx    = addr_q[ADDR_WIDTH+1:2];
    assign is_word = (smask_q[2:0] == 3'b111);
    assign is_half = (smask_q[2:0] == 3'b011);
    assign is_mmio = (addr_q == MMIO_LED_ADDR);
    assign is_oob  = !is_mmio && ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal = (is_half & addr_q[0]) | (is_word & (|addr_q[1:0]));
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        led_ext = '0;
        led_ext[LED_WIDTH-1:0] = led_q;
    end

    // The LED register stands in for the RAM word so MMIO shares the lane logic.
    assign src = is_mmio ? led_ext : word_q;

    always_comb begin
        byte_v = src[{addr_q[1:0], 3'b000} +: 8];
        half_v = addr_q[1] ? src[31:16] : src[15:0];
        if (is_word)
            ld_val = src;
        else if (is_half)
            ld_val = smask_q[3] ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        else
            ld_val = smask_q[3] ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
    end

    always_comb begin
        if (is_word) begin
            be     = 4'b1111;
            st_rep = wdata_q;
        end else if (is_half) begin
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            st_rep = {2{wdata_q[15:0]}};
        end else begin
            be     = 4'b0001 << addr_q[1:0];
            st_rep = {4{wdata_q[7:0]}};
        end
        for (int i = 0; i < 4; i++)
            st_val[i*8 +: 8] = be[i] ? st_rep[i*8 +: 8] : src[i*8 +: 8];
    end

    assign ram_we = (state_q == WRITE) && !is_mmio && !is_oob && !misal;

    // RAM has no reset so it maps onto block memory; reset only blocks the write via state_q.
    always_ff @(posedge clk) begin
        if (state_q == FETCH) word_q <= ram_q[widx];
        if (ram_we)           ram_q[widx] <= st_val;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        smask_d = smask_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        stall_d = stall_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                addr_d  = bus.addr;
                wdata_d = bus.write_data;
                smask_d = bus.sign_mask;
                rd_d    = bus.memread;
                wr_d    = bus.memwrite;
                if (bus.memread | bus.memwrite) begin
                    state_d = FETCH;
                    stall_d = 1'b1;
                end
            end
            FETCH: state_d = wr_q ? WRITE : READ;
            READ: begin
                rdata_d = (is_oob | misal) ? 32'h0 : ld_val;
                mis_d   = mis_q | misal;
                stall_d = 1'b0;
                state_d = IDLE;
            end
            WRITE: begin
                if (is_mmio && !misal) led_d = st_val[LED_WIDTH-1:0];
                mis_d   = mis_q | misal;
                stall_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            smask_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            stall_q <= 1'b0;
            rdata_q <= '0;
            led_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            smask_q <= smask_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            stall_q <= stall_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.read_data = rdata_q;
    assign bus.clk_stall = stall_q;
    assign bus.led       = led_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign bus.misalign  = mis_q;
`else
    assign bus.misalign  = 1'b0;
`endif
endmodule
